// File: rtl/foodfight_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : foodfight_adc_pkg
// Description : Shared types and constants for the ADC0809-style channel
//               sequencer (state encoding, channel select type, default
//               conversion length).
// Revision    : 1.0 - initial release
// ============================================================================
package foodfight_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } adc_state_t;

    typedef logic [1:0] adc_ch_t;

    localparam adc_ch_t CH_AX0 = 2'd0;
    localparam adc_ch_t CH_AY0 = 2'd1;
    localparam adc_ch_t CH_AX1 = 2'd2;
    localparam adc_ch_t CH_AY1 = 2'd3;

    // 100 us at a 48 MHz master clock
    localparam int DEFAULT_CONV_CYCLES = 4800;

endpackage
`default_nettype wire

// File: rtl/adc_channel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_channel_sequencer_if
// Description : Stick inputs, CPU start/channel strobe and conversion result
//               bundle. master = CPU/stick side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_channel_sequencer_if;
    import foodfight_adc_pkg::*;

    logic [7:0] AX0;
    logic [7:0] AY0;
    logic [7:0] AX1;
    logic [7:0] AY1;
    logic       START;
    adc_ch_t    CH;
    logic [7:0] DOUT;
    logic       EOC;
    logic       BUSY;
    adc_ch_t    CHSEL;

    modport master (
        output AX0, AY0, AX1, AY1, START, CH,
        input  DOUT, EOC, BUSY, CHSEL
    );

    modport slave (
        input  AX0, AY0, AX1, AY1, START, CH,
        output DOUT, EOC, BUSY, CHSEL
    );

endinterface
`default_nettype wire

// File: rtl/adc_conv_timer.sv
`default_nettype none
// ============================================================================
// Module      : adc_conv_timer
// Description : Loadable down-counter with enable and zero flag; times the
//               conversion busy period.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_conv_timer #(
    parameter int CNT_W = 13
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic [CNT_W-1:0] load_val,
    output logic                  zero
);

    logic [CNT_W-1:0] count;

    // Load has priority over counting; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/adc_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_channel_sequencer
// Description : ADC0809-style front end emulation. A START strobe selects one
//               of four stick channels, the value is snapshotted one cycle
//               later, and after CONV_CYCLES clocks it is presented on DOUT
//               with EOC high. A new START aborts any conversion in flight.
//               Optional macro ADC_AVG_EN: average the SAMPLE-cycle snapshot
//               with a second sample taken in the final count cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_channel_sequencer
    import foodfight_adc_pkg::*;
#(
    parameter int CONV_CYCLES = DEFAULT_CONV_CYCLES
) (
    input  wire logic                   MCLK,
    input  wire logic                   RESET,
    adc_channel_sequencer_if.slave      bus
);

    localparam int               CNT_W  = $clog2(CONV_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CONV_CYCLES - 1);

    adc_state_t state;
    adc_ch_t    chsel;
    logic [7:0] sample0;
    logic [7:0] dout;
    logic       eoc;
    logic       busy;
    logic [7:0] selected;
    logic [7:0] result;
    logic       cnt_zero;

    // Live channel value picked by the latched channel select.
    always_comb begin
        selected = bus.AX0;
        case (chsel)
            CH_AX0:  selected = bus.AX0;
            CH_AY0:  selected = bus.AY0;
            CH_AX1:  selected = bus.AX1;
            CH_AY1:  selected = bus.AY1;
            default: selected = bus.AX0;
        endcase
    end

`ifdef ADC_AVG_EN
    logic [8:0] avg_sum;
    // Rounded mean of the snapshot and the final-cycle sample.
    assign avg_sum = {1'b0, sample0} + {1'b0, selected} + 9'd1;
    assign result  = avg_sum[8:1];
`else
    assign result  = sample0;
`endif

    adc_conv_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (MCLK),
        .rst      (RESET),
        .load     (state == SAMPLE),
        .en       ((state == CONVERT) && !bus.START),
        .load_val (RELOAD),
        .zero     (cnt_zero)
    );

    // Sequencer FSM: START in any state (re)starts, which also covers abort
    // and discards a completion coinciding with the restart.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state   <= IDLE;
            chsel   <= CH_AX0;
            sample0 <= 8'h00;
            dout    <= 8'h00;
            eoc     <= 1'b1;
            busy    <= 1'b0;
        end else if (bus.START) begin
            chsel   <= bus.CH;
            state   <= SAMPLE;
            eoc     <= 1'b0;
            busy    <= 1'b1;
        end else begin
            case (state)
                SAMPLE: begin
                    sample0 <= selected;
                    state   <= CONVERT;
                end
                CONVERT: begin
                    if (cnt_zero) begin
                        dout  <= result;
                        eoc   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign bus.DOUT  = dout;
    assign bus.EOC   = eoc;
    assign bus.BUSY  = busy;
    assign bus.CHSEL = chsel;

endmodule
`default_nettype wire

// File: tb/tb_adc_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_channel_sequencer
// Description : Self-checking bench. Two sequencers (CONV_CYCLES=4 and 1)
//               are compared every cycle against a timeline model, plus
//               literal expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_channel_sequencer;
    import foodfight_adc_pkg::*;

    localparam int C0 = 4;
    localparam int C1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_channel_sequencer_if bus0();
    adc_channel_sequencer_if bus1();

    adc_channel_sequencer #(.CONV_CYCLES(C0)) dut0 (
        .MCLK  (clk),
        .RESET (rst),
        .bus   (bus0.slave)
    );

    adc_channel_sequencer #(.CONV_CYCLES(C1)) dut1 (
        .MCLK  (clk),
        .RESET (rst),
        .bus   (bus1.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model state per instance: outputs, snapshot and event timeline.
    logic [7:0] m_dout [2];
    logic       m_eoc  [2];
    logic       m_busy [2];
    logic [1:0] m_chsel[2];
    logic [7:0] m_snap [2];
    int         m_sample_at[2];
    int         m_done_at  [2];

`ifdef ADC_AVG_EN
    localparam logic [7:0] EXP3 = 8'h80;
`else
    localparam logic [7:0] EXP3 = 8'h10;
`endif

    // Event-timeline model: START schedules a snapshot one cycle later and a
    // completion cc cycles after that; RESET or a new START cancels it.
    task automatic model_step(input int k, input int cc, input logic r,
                              input logic s, input logic [1:0] ch,
                              input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1);
        logic [7:0] vals[4];
        logic [7:0] cur;
        logic [8:0] sum;
        vals[0] = a0; vals[1] = b0; vals[2] = a1; vals[3] = b1;
        cur = vals[m_chsel[k]];
        if (r) begin
            m_dout[k] = 8'h00; m_eoc[k] = 1'b1; m_busy[k] = 1'b0;
            m_chsel[k] = 2'd0; m_snap[k] = 8'h00;
            m_sample_at[k] = -1; m_done_at[k] = -1;
        end else if (s) begin
            m_chsel[k] = ch; m_eoc[k] = 1'b0; m_busy[k] = 1'b1;
            m_sample_at[k] = cyc + 1;
            m_done_at[k]   = cyc + 1 + cc;
        end else begin
            if (cyc == m_sample_at[k]) m_snap[k] = cur;
            if (cyc == m_done_at[k]) begin
                sum = {1'b0, m_snap[k]} + {1'b0, cur} + 9'd1;
`ifdef ADC_AVG_EN
                m_dout[k] = sum[8:1];
`else
                m_dout[k] = m_snap[k];
`endif
                m_eoc[k] = 1'b1; m_busy[k] = 1'b0; m_done_at[k] = -1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, C0, rst, bus0.START, bus0.CH, bus0.AX0, bus0.AY0, bus0.AX1, bus0.AY1);
        model_step(1, C1, rst, bus1.START, bus1.CH, bus1.AX0, bus1.AY0, bus1.AX1, bus1.AY1);
        if (rst) chk_en = 1'b1;
        cyc++;
    end

    task automatic cmp(input int k, input logic [7:0] d, input logic e,
                       input logic b, input logic [1:0] c);
        checks++;
        if (d !== m_dout[k] || e !== m_eoc[k] || b !== m_busy[k] || c !== m_chsel[k]) begin
            errors++;
            $display("FAIL model_dut%0d cyc=%0d dout=%h/%h eoc=%b/%b busy=%b/%b chsel=%0d/%0d (actual/required)",
                     k, cyc, d, m_dout[k], e, m_eoc[k], b, m_busy[k], c, m_chsel[k]);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, bus0.DOUT, bus0.EOC, bus0.BUSY, bus0.CHSEL);
            cmp(1, bus1.DOUT, bus1.EOC, bus1.BUSY, bus1.CHSEL);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] vals1[4];
        vals1[0] = 8'h3C; vals1[1] = 8'hA5; vals1[2] = 8'h69; vals1[3] = 8'hC3;
        bus0.AX0 = 8'h00; bus0.AY0 = 8'h00; bus0.AX1 = 8'h00; bus0.AY1 = 8'h00;
        bus0.START = 1'b0; bus0.CH = 2'd0;
        bus1.AX0 = vals1[0]; bus1.AY0 = vals1[1]; bus1.AX1 = vals1[2]; bus1.AY1 = vals1[3];
        bus1.START = 1'b0; bus1.CH = 2'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: START coinciding with RESET is ignored
        bus0.START = 1'b1; bus0.CH = 2'd3;
        bus1.START = 1'b1; bus1.CH = 2'd3;
        @(negedge clk);
        rst = 1'b0; bus0.START = 1'b0; bus1.START = 1'b0;
        @(negedge clk);
        chk("rst_dout",  bus0.DOUT, 8'h00);
        chk("rst_eoc",   {7'd0, bus0.EOC}, 8'h01);
        chk("rst_busy",  {7'd0, bus0.BUSY}, 8'h00);
        chk("rst_chsel", {6'd0, bus0.CHSEL}, 8'h00);

        // 2: basic conversion on AY0
        bus0.AY0 = 8'h5A; bus0.CH = 2'd1; bus0.START = 1'b1;
        @(negedge clk); bus0.START = 1'b0;
        chk("t2_busy_t1", {7'd0, bus0.BUSY}, 8'h01);
        chk("t2_eoc_t1",  {7'd0, bus0.EOC}, 8'h00);
        repeat (4) @(negedge clk);
        chk("t2_eoc_t5",  {7'd0, bus0.EOC}, 8'h00);
        @(negedge clk);
        chk("t2_eoc_t6",  {7'd0, bus0.EOC}, 8'h01);
        chk("t2_busy_t6", {7'd0, bus0.BUSY}, 8'h00);
        chk("t2_dout_t6", bus0.DOUT, 8'h5A);
        chk("t2_chsel",   {6'd0, bus0.CHSEL}, 8'h01);

        // 3: input change after the SAMPLE cycle
        bus0.AX1 = 8'h10; bus0.CH = 2'd2; bus0.START = 1'b1;
        @(negedge clk); bus0.START = 1'b0;
        repeat (2) @(negedge clk);
        bus0.AX1 = 8'hF0;
        repeat (3) @(negedge clk);
        chk("t3_dout_t6", bus0.DOUT, EXP3);
        chk("t3_eoc_t6",  {7'd0, bus0.EOC}, 8'h01);

        // 4: abort by a second START
        bus0.AX0 = 8'h11; bus0.AY1 = 8'h22; bus0.CH = 2'd0; bus0.START = 1'b1;
        @(negedge clk); bus0.START = 1'b0;
        repeat (2) @(negedge clk);
        bus0.CH = 2'd3; bus0.START = 1'b1;
        @(negedge clk); bus0.START = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_eoc_t8",  {7'd0, bus0.EOC}, 8'h00);
        chk("t4_hold_t8", bus0.DOUT, EXP3);
        @(negedge clk);
        chk("t4_dout_t9", bus0.DOUT, 8'h22);
        chk("t4_eoc_t9",  {7'd0, bus0.EOC}, 8'h01);
        chk("t4_chsel",   {6'd0, bus0.CHSEL}, 8'h03);

        // 5: RESET mid-conversion
        bus0.CH = 2'd0; bus0.START = 1'b1;
        @(negedge clk); bus0.START = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t5_eoc",  {7'd0, bus0.EOC}, 8'h01);
        chk("t5_busy", {7'd0, bus0.BUSY}, 8'h00);
        chk("t5_dout", bus0.DOUT, 8'h00);
        repeat (10) @(negedge clk);
        chk("t5_late_eoc",  {7'd0, bus0.EOC}, 8'h01);
        chk("t5_late_dout", bus0.DOUT, 8'h00);

        // 6: CONV_CYCLES=1, back-to-back over all channels
        for (int ch = 0; ch < 4; ch++) begin
            bus1.CH = 2'(ch); bus1.START = 1'b1;
            @(negedge clk); bus1.START = 1'b0;
            chk("t6_busy_t1", {7'd0, bus1.BUSY}, 8'h01);
            @(negedge clk);
            chk("t6_eoc_t2",  {7'd0, bus1.EOC}, 8'h00);
            @(negedge clk);
            chk("t6_eoc_t3",  {7'd0, bus1.EOC}, 8'h01);
            chk("t6_dout_t3", bus1.DOUT, vals1[ch]);
            chk("t6_chsel",   {6'd0, bus1.CHSEL}, 8'(ch));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
